// File: rtl/square_command_queue.sv
// Command queue in front of the square renderer.
// Buffers {x, y, size, colour} draw commands in a small FIFO and hands them to
// the renderer one at a time. Each command is held with enable low for one
// cycle so the renderer re-arms, then enable is raised until the renderer
// reports has_finished or the watchdog expires.
module square_command_queue #(
   parameter int X_WIDTH      = 8,
   parameter int Y_WIDTH      = 7,
   parameter int SQUARE_WIDTH = 5,
   parameter int COLOR_WIDTH  = 3,
   parameter int DEPTH        = 4,
   parameter int TIMEOUT      = 4096
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic [X_WIDTH-1:0]          i_cmd_x,
   input  logic [Y_WIDTH-1:0]          i_cmd_y,
   input  logic [SQUARE_WIDTH-1:0]     i_cmd_size,
   input  logic [COLOR_WIDTH-1:0]      i_cmd_color,
   output logic [X_WIDTH-1:0]          o_sq_origin_x,
   output logic [Y_WIDTH-1:0]          o_sq_origin_y,
   output logic [SQUARE_WIDTH-1:0]     o_sq_size,
   output logic                        o_sq_enable,
   input  logic                        i_sq_finished,
   output logic [COLOR_WIDTH-1:0]      o_active_color,
   output logic                        o_draw_done,
   output logic                        o_timeout_err,
   output logic [$clog2(DEPTH):0]      o_queue_count,
   output logic                        o_busy
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = X_WIDTH + Y_WIDTH + SQUARE_WIDTH + COLOR_WIDTH;
   localparam int WD_W    = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_DRAW    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [ENTRY_W-1:0]      r_mem [DEPTH];
   logic [PTR_W-1:0]        r_head;
   logic [PTR_W-1:0]        r_tail;
   logic [CNT_W-1:0]        r_count;

   // Sequencer state
   state_t                  r_state;
   state_t                  w_state_next;
   logic [WD_W-1:0]         r_wdog;

   // Registered outputs
   logic                    r_cmd_ready;
   logic [X_WIDTH-1:0]      r_sq_origin_x;
   logic [Y_WIDTH-1:0]      r_sq_origin_y;
   logic [SQUARE_WIDTH-1:0] r_sq_size;
   logic [COLOR_WIDTH-1:0]  r_active_color;
   logic                    r_sq_enable;
   logic                    r_draw_done;
   logic                    r_timeout_err;
   logic                    r_busy;

   // Combinational helpers
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_timeout_hit;
   logic [CNT_W-1:0]        w_count_next;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == CNT_W'(0));
   // Full blocks the push even when a pop frees a slot on the same edge.
   assign w_push  = i_cmd_valid && !w_full;

   // Next-state logic: pop only when leaving IDLE; finished beats timeout in DRAW.
   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_next = S_LOAD;
               w_pop        = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_LOAD: begin
            w_state_next = S_DRAW;
         end
         S_DRAW: begin
            if (i_sq_finished) begin
               w_state_next = S_RELEASE;
            end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
               w_state_next  = S_RELEASE;
               w_timeout_hit = 1'b1;
            end else begin
               w_state_next = S_DRAW;
            end
         end
         S_RELEASE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Occupancy after this edge's push/pop.
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // FIFO write side, pointers and occupancy; pointers wrap modulo DEPTH.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= {i_cmd_x, i_cmd_y, i_cmd_size, i_cmd_color};
            r_tail        <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= w_count_next;
      end
   end

   // State register and draw watchdog (cleared in LOAD, counts in DRAW).
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_wdog  <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_LOAD) begin
            r_wdog <= '0;
         end else if (r_state == S_DRAW) begin
            r_wdog <= r_wdog + WD_W'(1);
         end
      end
   end

   // Renderer-facing outputs: command fields latch on pop and hold until the next pop.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sq_origin_x  <= '0;
         r_sq_origin_y  <= '0;
         r_sq_size      <= '0;
         r_active_color <= '0;
         r_sq_enable    <= 1'b0;
         r_draw_done    <= 1'b0;
      end else begin
         if (w_pop) begin
            {r_sq_origin_x, r_sq_origin_y, r_sq_size, r_active_color} <= r_mem[r_head];
         end
         r_sq_enable <= (w_state_next == S_DRAW);
         r_draw_done <= (w_state_next == S_RELEASE);
      end
   end

   // Status outputs; timeout_err is sticky until reset.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cmd_ready   <= 1'b1;
         r_timeout_err <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_cmd_ready   <= (w_count_next != CNT_W'(DEPTH));
         r_timeout_err <= r_timeout_err | w_timeout_hit;
         r_busy        <= (w_state_next != S_IDLE) || (w_count_next != CNT_W'(0));
      end
   end

   assign o_cmd_ready    = r_cmd_ready;
   assign o_sq_origin_x  = r_sq_origin_x;
   assign o_sq_origin_y  = r_sq_origin_y;
   assign o_sq_size      = r_sq_size;
   assign o_active_color = r_active_color;
   assign o_sq_enable    = r_sq_enable;
   assign o_draw_done    = r_draw_done;
   assign o_timeout_err  = r_timeout_err;
   assign o_queue_count  = r_count;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_square_command_queue.sv
// Testbench for square_command_queue: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
module tb_square_command_queue;

   localparam int XW = 8, YW = 7, SW = 5, CW = 3, DEPTH = 4;
   localparam int TO = 4096, TO2 = 8;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [SW-1:0] s;
      logic [CW-1:0] c;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Main DUT (default timeout)
   logic          d_valid, d_ready, d_en, d_done, d_terr, d_busy, d_fin;
   logic [XW-1:0] d_x, d_ox;
   logic [YW-1:0] d_y, d_oy;
   logic [SW-1:0] d_sz, d_osz;
   logic [CW-1:0] d_col, d_ocol;
   logic [2:0]    d_count;

   square_command_queue #(.TIMEOUT(TO)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_cmd_valid(d_valid), .o_cmd_ready(d_ready),
      .i_cmd_x(d_x), .i_cmd_y(d_y), .i_cmd_size(d_sz), .i_cmd_color(d_col),
      .o_sq_origin_x(d_ox), .o_sq_origin_y(d_oy), .o_sq_size(d_osz), .o_sq_enable(d_en),
      .i_sq_finished(d_fin), .o_active_color(d_ocol), .o_draw_done(d_done),
      .o_timeout_err(d_terr), .o_queue_count(d_count), .o_busy(d_busy)
   );

   // Second DUT with a short watchdog and the renderer tied off
   logic          t_valid, t_ready, t_en, t_done, t_terr, t_busy;
   logic          t_fin;
   logic [XW-1:0] t_x, t_ox;
   logic [YW-1:0] t_y, t_oy;
   logic [SW-1:0] t_sz, t_osz;
   logic [CW-1:0] t_col, t_ocol;
   logic [2:0]    t_count;
   assign t_fin = 1'b0;

   square_command_queue #(.TIMEOUT(TO2)) u_dut_to (
      .i_clock(clk), .i_reset(rst), .i_cmd_valid(t_valid), .o_cmd_ready(t_ready),
      .i_cmd_x(t_x), .i_cmd_y(t_y), .i_cmd_size(t_sz), .i_cmd_color(t_col),
      .o_sq_origin_x(t_ox), .o_sq_origin_y(t_oy), .o_sq_size(t_osz), .o_sq_enable(t_en),
      .i_sq_finished(t_fin), .o_active_color(t_ocol), .o_draw_done(t_done),
      .o_timeout_err(t_terr), .o_queue_count(t_count), .o_busy(t_busy)
   );

   logic [30:0] dut_vec;
   assign dut_vec = {d_ready, d_count, d_ox, d_oy, d_osz, d_ocol, d_en, d_done, d_terr, d_busy};

   // Renderer model: raise finished on the fin_n-th enabled cycle (0 = stall forever)
   int fin_n;
   int rcnt;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         rcnt  = 0;
         d_fin = 1'b0;
      end else begin
         if (d_en) rcnt = rcnt + 1;
         else      rcnt = 0;
         d_fin = (d_en && fin_n != 0 && rcnt >= fin_n);
      end
   end

   // Reference model: command queue plus phase of the current command
   // (0 waiting, 1 re-arm, 2 drawing, 3 retiring).
   cmd_t          m_q[$];
   cmd_t          m_h;
   int            m_stage, m_wd;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic [SW-1:0] m_sz;
   logic [CW-1:0] m_col;
   logic          m_terr;
   logic          m_acc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_stage = 0; m_wd = 0; m_terr = 1'b0;
         m_x = '0; m_y = '0; m_sz = '0; m_col = '0;
      end else begin
         m_acc = d_valid && (m_q.size() < DEPTH);
         case (m_stage)
            0: if (m_q.size() != 0) begin
                  m_h = m_q.pop_front();
                  m_x = m_h.x; m_y = m_h.y; m_sz = m_h.s; m_col = m_h.c;
                  m_stage = 1;
               end
            1: begin m_wd = 0; m_stage = 2; end
            2: begin
                  if (d_fin) m_stage = 3;
                  else if (m_wd == TO - 1) begin m_stage = 3; m_terr = 1'b1; end
                  m_wd = m_wd + 1;
               end
            default: m_stage = 0;
         endcase
         if (m_acc) m_q.push_back({d_x, d_y, d_sz, d_col});
      end
   end

   function automatic logic [30:0] exp_vec();
      return {(m_q.size() < DEPTH), 3'(m_q.size()), m_x, m_y, m_sz, m_col,
              (m_stage == 2), (m_stage == 3), m_terr, (m_stage != 0 || m_q.size() != 0)};
   endfunction

   task automatic test_reset;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (dut_vec !== {1'b1, 30'd0}) begin
         n_err++; $display("FAIL reset_async: got %h want %h", dut_vec, {1'b1, 30'd0});
      end
      n_cmp++;
      if ({t_ready, t_count, t_en, t_done, t_terr, t_busy} !== 8'b1000_0000) begin
         n_err++; $display("FAIL reset_async_to: got %b want 10000000",
                           {t_ready, t_count, t_en, t_done, t_terr, t_busy});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single;
      int en_cycles, dones;
      fin_n = 16;
      @(negedge clk);
      d_valid = 1'b1; d_x = 8'd10; d_y = 7'd20; d_sz = 5'd3; d_col = 3'd5;
      @(negedge clk);
      d_valid = 1'b0;
      n_cmp++;
      if ({d_count, d_en} !== {3'd1, 1'b0}) begin
         n_err++; $display("FAIL single_accept: got count=%0d en=%b want count=1 en=0", d_count, d_en);
      end
      @(negedge clk);
      n_cmp++;
      if ({d_ox, d_oy, d_osz, d_ocol, d_en} !== {8'd10, 7'd20, 5'd3, 3'd5, 1'b0}) begin
         n_err++; $display("FAIL single_load: got x=%0d y=%0d s=%0d c=%0d en=%b want 10 20 3 5 0",
                           d_ox, d_oy, d_osz, d_ocol, d_en);
      end
      en_cycles = 0; dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL single_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         if (i == 0) begin
            n_cmp++;
            if (d_en !== 1'b1) begin n_err++; $display("FAIL single_en_start: got %b want 1", d_en); end
         end
         if (d_en) en_cycles++;
         if (d_done) dones++;
      end
      n_cmp++;
      if (en_cycles != 16) begin n_err++; $display("FAIL single_en_len: got %0d want 16", en_cycles); end
      n_cmp++;
      if (dones != 1) begin n_err++; $display("FAIL single_done: got %0d want 1", dones); end
      n_cmp++;
      if (d_busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", d_busy); end
   endtask

   task automatic test_fill;
      int low, seen;
      logic prev_en;
      logic [XW-1:0] ret[$];
      fin_n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         d_valid = 1'b1; d_x = 8'(40 + k); d_y = 7'($urandom); d_sz = 5'($urandom); d_col = 3'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({d_count, d_ready} !== {3'd4, 1'b0}) begin
            n_err++; $display("FAIL fill_full: got count=%0d ready=%b want 4 0", d_count, d_ready);
         end
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL fill_model_hold: got %h want %h", dut_vec, exp_vec());
         end
      end
      d_valid = 1'b0;
      fin_n = 5;
      low = 0; seen = 1; prev_en = d_en;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL fill_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         if (d_done) ret.push_back(d_ox);
         if (d_en) begin
            if (!prev_en && seen != 0) begin
               n_cmp++;
               if (low != 3) begin n_err++; $display("FAIL fill_gap: got %0d low cycles want 3", low); end
            end
            low = 0;
         end else begin
            low++;
         end
         prev_en = d_en;
      end
      n_cmp++;
      if (ret.size() != 5) begin
         n_err++; $display("FAIL fill_retired: got %0d want 5", ret.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (ret[k] !== 8'(40 + k)) begin
               n_err++; $display("FAIL fill_order %0d: got %0d want %0d", k, ret[k], 40 + k);
            end
         end
      end
   endtask

   task automatic test_push_pop;
      int pushed, hits;
      logic pend;
      logic [XW-1:0] head_x;
      logic [XW-1:0] ret[$];
      fin_n = 3; pushed = 0; hits = 0; pend = 1'b0; head_x = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL pp_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         if (pend) begin
            n_cmp++;
            if ({d_count, d_ox} !== {3'd2, head_x}) begin
               n_err++; $display("FAIL pp_same_edge: got count=%0d x=%0d want 2 %0d", d_count, d_ox, head_x);
            end
            pend = 1'b0;
         end
         if (d_done) ret.push_back(d_ox);
         if (pushed < 10 && (m_q.size() < 2 || (m_stage == 0 && m_q.size() == 2))) begin
            if (m_stage == 0 && m_q.size() == 2) begin
               pend = 1'b1; head_x = m_q[0].x; hits++;
            end
            d_valid = 1'b1; d_x = 8'(100 + pushed); d_y = 7'($urandom); d_sz = 5'($urandom); d_col = 3'($urandom);
            pushed++;
         end else begin
            d_valid = 1'b0;
            if (pushed == 10 && m_stage == 0 && m_q.size() == 0) break;
         end
      end
      d_valid = 1'b0;
      n_cmp++;
      if (hits == 0) begin n_err++; $display("FAIL pp_hits: got 0 want >0"); end
      n_cmp++;
      if (ret.size() != 10) begin
         n_err++; $display("FAIL pp_retired: got %0d want 10", ret.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (ret[k] !== 8'(100 + k)) begin
               n_err++; $display("FAIL pp_order %0d: got %0d want %0d", k, ret[k], 100 + k);
            end
         end
      end
   endtask

   task automatic test_timeout;
      int win, run, len1, len2, dones, early;
      logic terr1;
      logic [22:0] second;
      @(negedge clk);
      t_valid = 1'b1; t_x = 8'd7; t_y = 7'd3; t_sz = 5'd2; t_col = 3'd1;
      @(negedge clk);
      t_x = 8'd9; t_y = 7'd4; t_sz = 5'd6; t_col = 3'd2;
      @(negedge clk);
      t_valid = 1'b0;
      win = 0; run = 0; len1 = 0; len2 = 0; dones = 0; early = 0; terr1 = 1'b0; second = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (t_en) begin
            if (run == 0) begin
               win++;
               if (win == 2) second = {t_ox, t_oy, t_osz, t_ocol};
            end
            run++;
            if (win == 1 && t_terr) early++;
         end else if (run != 0) begin
            if (win == 1) len1 = run;
            if (win == 2) len2 = run;
            run = 0;
         end
         if (t_done) begin
            dones++;
            if (dones == 1) terr1 = t_terr;
         end
      end
      n_cmp++;
      if (win != 2) begin n_err++; $display("FAIL to_windows: got %0d want 2", win); end
      n_cmp++;
      if (len1 != TO2) begin n_err++; $display("FAIL to_len1: got %0d want %0d", len1, TO2); end
      n_cmp++;
      if (len2 != TO2) begin n_err++; $display("FAIL to_len2: got %0d want %0d", len2, TO2); end
      n_cmp++;
      if (early != 0) begin n_err++; $display("FAIL to_early_err: got %0d want 0", early); end
      n_cmp++;
      if (terr1 !== 1'b1) begin n_err++; $display("FAIL to_err_at_done: got %b want 1", terr1); end
      n_cmp++;
      if (dones != 2) begin n_err++; $display("FAIL to_dones: got %0d want 2", dones); end
      n_cmp++;
      if (second !== {8'd9, 7'd4, 5'd6, 3'd2}) begin
         n_err++; $display("FAIL to_second_cmd: got %h want %h", second, {8'd9, 7'd4, 5'd6, 3'd2});
      end
      n_cmp++;
      if ({t_terr, t_ready, t_count, t_busy, t_en, t_done} !== {1'b1, 1'b1, 3'd0, 3'b000}) begin
         n_err++; $display("FAIL to_final: got %b want 11000000",
                           {t_terr, t_ready, t_count, t_busy, t_en, t_done});
      end
   endtask

   task automatic test_reset_mid;
      int dones;
      logic ok;
      logic [XW-1:0] rx;
      fin_n = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         d_valid = 1'b1; d_x = 8'(60 + k); d_y = 7'd1; d_sz = 5'd1; d_col = 3'd1;
      end
      @(negedge clk);
      d_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (d_en === 1'b1 && d_count === 3'd2) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rm_setup: got en=%b count=%0d want 1 2", d_en, d_count); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (dut_vec !== {1'b1, 30'd0}) begin
         n_err++; $display("FAIL rm_reset: got %h want %h", dut_vec, {1'b1, 30'd0});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fin_n = 4;
      @(negedge clk);
      d_valid = 1'b1; d_x = 8'd70; d_y = 7'd5; d_sz = 5'd5; d_col = 3'd5;
      dones = 0; rx = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         d_valid = 1'b0;
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL rm_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         if (d_done) begin dones++; rx = d_ox; end
      end
      n_cmp++;
      if ({dones, rx} !== {32'd1, 8'd70}) begin
         n_err++; $display("FAIL rm_after: got dones=%0d x=%0d want 1 70", dones, rx);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL rand_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
         end
         if (!d_en) fin_n = $urandom_range(1, 12);
         if (i < 400) begin
            d_valid = ($urandom_range(0, 2) != 0);
            d_x = 8'($urandom); d_y = 7'($urandom); d_sz = 5'($urandom); d_col = 3'($urandom);
         end else begin
            d_valid = 1'b0;
         end
      end
      n_cmp++;
      if (d_busy !== 1'b0) begin n_err++; $display("FAIL rand_drain: got busy=%b want 0", d_busy); end
   endtask

   // Test sequence
   initial begin
      d_valid = 1'b0; d_x = '0; d_y = '0; d_sz = '0; d_col = '0;
      t_valid = 1'b0; t_x = '0; t_y = '0; t_sz = '0; t_col = '0;
      fin_n = 0;
      test_reset;
      test_single;
      test_fill;
      test_push_pop;
      test_timeout;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
